doc_safety_apb_arbiter: RTL and testbench

//  Two-requester APB arbiter in front of the single shared-memory APB completer

---
 rtl/doc_safety_apb_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_doc_safety_apb_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doc_safety_apb_arbiter.sv
// Two-requester round-robin APB arbiter in front of the shared safety-payload
// memory, with a completer-response watchdog that aborts hung accesses.
module doc_safety_apb_arbiter #(
  parameter int unsigned P_ADDR_WIDTH     = 4,
  parameter int unsigned P_DATA_WIDTH     = 32,
  parameter int unsigned P_PREADY_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [P_ADDR_WIDTH-1:0] s0_apb_paddr,
  input  logic                    s0_apb_pwrite,
  input  logic                    s0_apb_psel,
  input  logic                    s0_apb_penable,
  input  logic [P_DATA_WIDTH-1:0] s0_apb_pwdata,
  output logic [P_DATA_WIDTH-1:0] s0_apb_prdata,
  output logic                    s0_apb_pready,
  output logic                    s0_apb_pslverr,

  input  logic [P_ADDR_WIDTH-1:0] s1_apb_paddr,
  input  logic                    s1_apb_pwrite,
  input  logic                    s1_apb_psel,
  input  logic                    s1_apb_penable,
  input  logic [P_DATA_WIDTH-1:0] s1_apb_pwdata,
  output logic [P_DATA_WIDTH-1:0] s1_apb_prdata,
  output logic                    s1_apb_pready,
  output logic                    s1_apb_pslverr,

  output logic [P_ADDR_WIDTH-1:0] m_apb_paddr,
  output logic                    m_apb_pwrite,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic [P_DATA_WIDTH-1:0] m_apb_pwdata,
  input  logic [P_DATA_WIDTH-1:0] m_apb_prdata,
  input  logic                    m_apb_pready,
  input  logic                    m_apb_pslverr,

  output logic [1:0]              grant,
  output logic                    timeout_err,
  output logic [7:0]              timeout_count
);

  localparam int unsigned WDOG_W = $clog2(P_PREADY_TIMEOUT + 1);
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic                    last_grant, last_grant_nxt;
  logic [WDOG_W-1:0]       wdog, wdog_nxt;
  logic [1:0]              grant_nxt;
  logic [P_ADDR_WIDTH-1:0] m_paddr_nxt;
  logic                    m_pwrite_nxt, m_psel_nxt, m_penable_nxt;
  logic [P_DATA_WIDTH-1:0] m_pwdata_nxt;
  logic [P_DATA_WIDTH-1:0] s0_prdata_nxt, s1_prdata_nxt;
  logic                    s0_pready_nxt, s1_pready_nxt;
  logic                    s0_pslverr_nxt, s1_pslverr_nxt;
  logic                    timeout_err_nxt;
  logic [CNT_W-1:0]        timeout_count_nxt;

  logic                    pick_s1_c;
  logic [P_DATA_WIDTH-1:0] resp_data_c;
  logic                    wdog_expired_c;
  logic                    unused_penable_c;

  // penable belongs to the requester handshake; the arbiter only needs psel
  assign unused_penable_c = &{1'b0, s0_apb_penable, s1_apb_penable};

  // s1 wins if it is alone, or if both request and s0 was served last
  assign pick_s1_c      = s1_apb_psel && (!s0_apb_psel || !last_grant);
  assign resp_data_c    = m_apb_pwrite ? '0 : m_apb_prdata;
  assign wdog_expired_c = (wdog == WDOG_W'(P_PREADY_TIMEOUT - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_nxt         = state;
    last_grant_nxt    = last_grant;
    wdog_nxt          = wdog;
    grant_nxt         = grant;
    m_paddr_nxt       = m_apb_paddr;
    m_pwrite_nxt      = m_apb_pwrite;
    m_psel_nxt        = m_apb_psel;
    m_penable_nxt     = m_apb_penable;
    m_pwdata_nxt      = m_apb_pwdata;
    s0_prdata_nxt     = s0_apb_prdata;
    s1_prdata_nxt     = s1_apb_prdata;
    s0_pready_nxt     = s0_apb_pready;
    s1_pready_nxt     = s1_apb_pready;
    s0_pslverr_nxt    = s0_apb_pslverr;
    s1_pslverr_nxt    = s1_apb_pslverr;
    timeout_err_nxt   = timeout_err;
    timeout_count_nxt = timeout_count;

    case (state)
      S_IDLE: begin
        if (s0_apb_psel || s1_apb_psel) begin
          m_paddr_nxt    = pick_s1_c ? s1_apb_paddr  : s0_apb_paddr;
          m_pwrite_nxt   = pick_s1_c ? s1_apb_pwrite : s0_apb_pwrite;
          m_pwdata_nxt   = pick_s1_c ? s1_apb_pwdata : s0_apb_pwdata;
          grant_nxt      = pick_s1_c ? 2'b10 : 2'b01;
          last_grant_nxt = pick_s1_c;
          m_psel_nxt     = 1'b1;
          m_penable_nxt  = 1'b0;
          state_nxt      = S_SETUP;
        end
      end

      S_SETUP: begin
        m_penable_nxt = 1'b1;
        wdog_nxt      = '0;
        state_nxt     = S_ACCESS;
      end

      S_ACCESS: begin
        wdog_nxt = wdog + WDOG_W'(1);
        if (m_apb_pready) begin
          if (grant[1]) begin
            s1_prdata_nxt  = resp_data_c;
            s1_pslverr_nxt = m_apb_pslverr;
            s1_pready_nxt  = 1'b1;
          end else begin
            s0_prdata_nxt  = resp_data_c;
            s0_pslverr_nxt = m_apb_pslverr;
            s0_pready_nxt  = 1'b1;
          end
          m_psel_nxt    = 1'b0;
          m_penable_nxt = 1'b0;
          state_nxt     = S_RESP;
        end else if (wdog_expired_c) begin
          // completer hung: abort and answer the requester with an error
          if (grant[1]) begin
            s1_prdata_nxt  = '0;
            s1_pslverr_nxt = 1'b1;
            s1_pready_nxt  = 1'b1;
          end else begin
            s0_prdata_nxt  = '0;
            s0_pslverr_nxt = 1'b1;
            s0_pready_nxt  = 1'b1;
          end
          m_psel_nxt      = 1'b0;
          m_penable_nxt   = 1'b0;
          timeout_err_nxt = 1'b1;
          if (timeout_count != {CNT_W{1'b1}}) begin
            timeout_count_nxt = timeout_count + CNT_W'(1);
          end
          state_nxt = S_RESP;
        end
      end

      S_RESP: begin
        s0_pready_nxt   = 1'b0;
        s1_pready_nxt   = 1'b0;
        s0_pslverr_nxt  = 1'b0;
        s1_pslverr_nxt  = 1'b0;
        timeout_err_nxt = 1'b0;
        grant_nxt       = 2'b00;
        state_nxt       = S_IDLE;
      end

      default: begin
        m_paddr_nxt   = '0;
        m_pwrite_nxt  = 1'b0;
        m_psel_nxt    = 1'b0;
        m_penable_nxt = 1'b0;
        m_pwdata_nxt  = '0;
        s0_pready_nxt = 1'b0;
        s1_pready_nxt = 1'b0;
        grant_nxt     = 2'b00;
        state_nxt     = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      last_grant     <= 1'b1;
      wdog           <= '0;
      grant          <= 2'b00;
      m_apb_paddr    <= '0;
      m_apb_pwrite   <= 1'b0;
      m_apb_psel     <= 1'b0;
      m_apb_penable  <= 1'b0;
      m_apb_pwdata   <= '0;
      s0_apb_prdata  <= '0;
      s1_apb_prdata  <= '0;
      s0_apb_pready  <= 1'b0;
      s1_apb_pready  <= 1'b0;
      s0_apb_pslverr <= 1'b0;
      s1_apb_pslverr <= 1'b0;
      timeout_err    <= 1'b0;
      timeout_count  <= '0;
    end else begin
      state          <= state_nxt;
      last_grant     <= last_grant_nxt;
      wdog           <= wdog_nxt;
      grant          <= grant_nxt;
      m_apb_paddr    <= m_paddr_nxt;
      m_apb_pwrite   <= m_pwrite_nxt;
      m_apb_psel     <= m_psel_nxt;
      m_apb_penable  <= m_penable_nxt;
      m_apb_pwdata   <= m_pwdata_nxt;
      s0_apb_prdata  <= s0_prdata_nxt;
      s1_apb_prdata  <= s1_prdata_nxt;
      s0_apb_pready  <= s0_pready_nxt;
      s1_apb_pready  <= s1_pready_nxt;
      s0_apb_pslverr <= s0_pslverr_nxt;
      s1_apb_pslverr <= s1_pslverr_nxt;
      timeout_err    <= timeout_err_nxt;
      timeout_count  <= timeout_count_nxt;
    end
  end

endmodule

// File: tb/tb_doc_safety_apb_arbiter.sv
// Directed bench for doc_safety_apb_arbiter: two APB requesters plus a
// behavioural completer with programmable wait states, error and hang.
module tb_doc_safety_apb_arbiter;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          clk;
  logic          reset;
  logic [AW-1:0] s0_apb_paddr, s1_apb_paddr, m_apb_paddr;
  logic          s0_apb_pwrite, s0_apb_psel, s0_apb_penable;
  logic          s1_apb_pwrite, s1_apb_psel, s1_apb_penable;
  logic [DW-1:0] s0_apb_pwdata, s1_apb_pwdata, m_apb_pwdata;
  logic [DW-1:0] s0_apb_prdata, s1_apb_prdata, m_apb_prdata;
  logic          s0_apb_pready, s0_apb_pslverr, s1_apb_pready, s1_apb_pslverr;
  logic          m_apb_pwrite, m_apb_psel, m_apb_penable, m_apb_pready, m_apb_pslverr;
  logic [1:0]    grant;
  logic          timeout_err;
  logic [7:0]    timeout_count;

  int vectors;
  int miscompares;

  // completer model controls and observations
  int            comp_waits;
  logic          comp_stuck;
  logic [DW-1:0] comp_rdata;
  logic          comp_err;
  int            comp_cnt;
  int            acc_len;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic          last_write;
  logic [1:0]    prev_grant;
  logic [1:0]    grant_log[$];

  doc_safety_apb_arbiter #(
    .P_ADDR_WIDTH    (AW),
    .P_DATA_WIDTH    (DW),
    .P_PREADY_TIMEOUT(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s0_apb_paddr  (s0_apb_paddr),
    .s0_apb_pwrite (s0_apb_pwrite),
    .s0_apb_psel   (s0_apb_psel),
    .s0_apb_penable(s0_apb_penable),
    .s0_apb_pwdata (s0_apb_pwdata),
    .s0_apb_prdata (s0_apb_prdata),
    .s0_apb_pready (s0_apb_pready),
    .s0_apb_pslverr(s0_apb_pslverr),
    .s1_apb_paddr  (s1_apb_paddr),
    .s1_apb_pwrite (s1_apb_pwrite),
    .s1_apb_psel   (s1_apb_psel),
    .s1_apb_penable(s1_apb_penable),
    .s1_apb_pwdata (s1_apb_pwdata),
    .s1_apb_prdata (s1_apb_prdata),
    .s1_apb_pready (s1_apb_pready),
    .s1_apb_pslverr(s1_apb_pslverr),
    .m_apb_paddr   (m_apb_paddr),
    .m_apb_pwrite  (m_apb_pwrite),
    .m_apb_psel    (m_apb_psel),
    .m_apb_penable (m_apb_penable),
    .m_apb_pwdata  (m_apb_pwdata),
    .m_apb_prdata  (m_apb_prdata),
    .m_apb_pready  (m_apb_pready),
    .m_apb_pslverr (m_apb_pslverr),
    .grant         (grant),
    .timeout_err   (timeout_err),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completer: answers on the ACCESS cycle after comp_waits wait states; also logs grant starts
  always @(negedge clk) begin
    if (reset) begin
      comp_cnt      = 0;
      m_apb_pready  = 1'b0;
      m_apb_pslverr = 1'b0;
    end else if (m_apb_psel && m_apb_penable) begin
      if (!comp_stuck && comp_cnt == comp_waits) begin
        m_apb_pready  = 1'b1;
        m_apb_pslverr = comp_err;
        m_apb_prdata  = comp_rdata;
        last_addr     = m_apb_paddr;
        last_wdata    = m_apb_pwdata;
        last_write    = m_apb_pwrite;
      end else begin
        m_apb_pready  = 1'b0;
        m_apb_pslverr = 1'b0;
      end
      comp_cnt = comp_cnt + 1;
      acc_len  = comp_cnt;
    end else begin
      comp_cnt      = 0;
      m_apb_pready  = 1'b0;
      m_apb_pslverr = 1'b0;
    end
    if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
    prev_grant = grant;
  end

  // One requester transaction; caller is #1 after a rising edge
  task automatic xfer(input int p, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                      output logic err, output logic tmo, output int lat);
    logic rdy;
    logic done;
    done = 1'b0;
    lat  = 0;
    rd   = '0;
    err  = 1'b0;
    tmo  = 1'b0;
    if (p == 0) begin
      s0_apb_paddr = a; s0_apb_pwrite = wr; s0_apb_pwdata = wd;
      s0_apb_psel = 1'b1; s0_apb_penable = 1'b0;
    end else begin
      s1_apb_paddr = a; s1_apb_pwrite = wr; s1_apb_pwdata = wd;
      s1_apb_psel = 1'b1; s1_apb_penable = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat = lat + 1;
      rdy = (p == 0) ? s0_apb_pready : s1_apb_pready;
      if (rdy) begin
        rd   = (p == 0) ? s0_apb_prdata : s1_apb_prdata;
        err  = (p == 0) ? s0_apb_pslverr : s1_apb_pslverr;
        tmo  = timeout_err;
        done = 1'b1;
        break;
      end
      if (p == 0) s0_apb_penable = 1'b1;
      else        s1_apb_penable = 1'b1;
    end
    if (p == 0) begin s0_apb_psel = 1'b0; s0_apb_penable = 1'b0; end
    else        begin s1_apb_psel = 1'b0; s1_apb_penable = 1'b0; end
    vectors = vectors + 1;
    if (!done) begin
      miscompares = miscompares + 1;
      $display("FAIL xfer_bound: requester %0d got no pready within 100 cycles", p);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vectors = vectors + 1;
    if ({grant, timeout_err, timeout_count, m_apb_psel, m_apb_penable, m_apb_pwrite} !== 13'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_ctrl: grant=%b terr=%b tcnt=%0d psel=%b pen=%b pwr=%b, want all 0",
               grant, timeout_err, timeout_count, m_apb_psel, m_apb_penable, m_apb_pwrite);
    end
    vectors = vectors + 1;
    if ({m_apb_paddr, m_apb_pwdata, s0_apb_prdata, s1_apb_prdata} !== '0 ||
        {s0_apb_pready, s0_apb_pslverr, s1_apb_pready, s1_apb_pslverr} !== 4'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_data: paddr=%h pwdata=%h s0rd=%h s1rd=%h s-flags=%b, want all 0",
               m_apb_paddr, m_apb_pwdata, s0_apb_prdata, s1_apb_prdata,
               {s0_apb_pready, s0_apb_pslverr, s1_apb_pready, s1_apb_pslverr});
    end
    reset = 1'b0;
  endtask

  task automatic test_write;
    logic [DW-1:0] rd;
    logic err, tmo;
    int lat, base;
    comp_waits = 2; comp_stuck = 1'b0; comp_rdata = 32'hFFFF_FFFF; comp_err = 1'b0;
    base = grant_log.size();
    xfer(0, 1'b1, 4'h1, 32'hA5A5_0001, rd, err, tmo, lat);
    vectors = vectors + 1;
    if (lat !== 5) begin
      miscompares = miscompares + 1;
      $display("FAIL write_latency: got %0d cycles, want 5", lat);
    end
    vectors = vectors + 1;
    if (last_addr !== 4'h1 || last_wdata !== 32'hA5A5_0001 || last_write !== 1'b1 || acc_len !== 3) begin
      miscompares = miscompares + 1;
      $display("FAIL write_completer: addr=%h data=%h wr=%b acc=%0d, want 1 a5a50001 1 3",
               last_addr, last_wdata, last_write, acc_len);
    end
    vectors = vectors + 1;
    if (rd !== 32'h0 || err !== 1'b0 || tmo !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL write_resp: prdata=%h pslverr=%b terr=%b, want 0 0 0", rd, err, tmo);
    end
    vectors = vectors + 1;
    if (grant_log.size() != base + 1 || grant_log[base] !== 2'b01) begin
      miscompares = miscompares + 1;
      $display("FAIL write_grant: log size %0d first %b, want 1 entry 01",
               grant_log.size() - base, grant_log[base]);
    end
    @(posedge clk);
    #1;
    vectors = vectors + 1;
    if (s0_apb_pready !== 1'b0 || grant !== 2'b00) begin
      miscompares = miscompares + 1;
      $display("FAIL write_pulse: pready=%b grant=%b one cycle later, want 0 00", s0_apb_pready, grant);
    end
  endtask

  task automatic test_simultaneous;
    logic [DW-1:0] rd0, rd1;
    logic e0, e1, t0, t1;
    int l0, l1, base;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    comp_waits = 0; comp_rdata = 32'h0000_1111;
    base = grant_log.size();
    fork
      xfer(0, 1'b0, 4'h2, 32'h0, rd0, e0, t0, l0);
      xfer(1, 1'b0, 4'h3, 32'h0, rd1, e1, t1, l1);
    join
    vectors = vectors + 1;
    if (grant_log.size() != base + 2 || grant_log[base] !== 2'b01 || grant_log[base+1] !== 2'b10) begin
      miscompares = miscompares + 1;
      $display("FAIL simul_order: %0d grants %b %b, want 01 then 10",
               grant_log.size() - base, grant_log[base], grant_log[base+1]);
    end
    vectors = vectors + 1;
    if (rd0 !== 32'h0000_1111 || rd1 !== 32'h0000_1111 || l0 !== 3) begin
      miscompares = miscompares + 1;
      $display("FAIL simul_data: rd0=%h rd1=%h lat0=%0d, want 00001111 00001111 3", rd0, rd1, l0);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] rd;
    logic err, tmo;
    int lat, base;
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    comp_waits = 1; comp_rdata = 32'h0000_2222;
    xfer(0, 1'b0, 4'h4, 32'h0, rd, err, tmo, lat);
    base = grant_log.size();
    fork
      begin
        logic [DW-1:0] r; logic e, t; int l;
        for (int k = 0; k < 3; k++) xfer(0, 1'b0, AW'(k), 32'h0, r, e, t, l);
      end
      begin
        logic [DW-1:0] r; logic e, t; int l;
        for (int k = 0; k < 3; k++) xfer(1, 1'b0, AW'(8 + k), 32'h0, r, e, t, l);
      end
    join
    vectors = vectors + 1;
    if (grant_log.size() != base + 6) begin
      miscompares = miscompares + 1;
      $display("FAIL b2b_count: %0d grants, want 6", grant_log.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        vectors = vectors + 1;
        if (grant_log[base+k] !== exp_seq[k]) begin
          miscompares = miscompares + 1;
          $display("FAIL b2b_order[%0d]: grant %b, want %b", k, grant_log[base+k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_rdata_err;
    logic [DW-1:0] rd;
    logic err, tmo;
    int lat;
    comp_waits = 0; comp_rdata = 32'h1234_5678; comp_err = 1'b0;
    xfer(0, 1'b0, 4'h5, 32'h0, rd, err, tmo, lat);
    vectors = vectors + 1;
    if (rd !== 32'h1234_5678 || err !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL s0_read: prdata=%h pslverr=%b, want 12345678 0", rd, err);
    end
    comp_rdata = 32'hDEAD_BEEF; comp_err = 1'b1;
    xfer(1, 1'b0, 4'h6, 32'h0, rd, err, tmo, lat);
    vectors = vectors + 1;
    if (rd !== 32'hDEAD_BEEF || err !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL s1_slverr: prdata=%h pslverr=%b, want deadbeef 1", rd, err);
    end
    vectors = vectors + 1;
    if (s0_apb_prdata !== 32'h1234_5678 || s0_apb_pslverr !== 1'b0 || s0_apb_pready !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL s0_untouched: prdata=%h pslverr=%b pready=%b, want 12345678 0 0",
               s0_apb_prdata, s0_apb_pslverr, s0_apb_pready);
    end
    comp_err = 1'b0;
    @(posedge clk);
    #1;
    vectors = vectors + 1;
    if (s1_apb_prdata !== 32'hDEAD_BEEF || s1_apb_pslverr !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL s1_hold: prdata=%h pslverr=%b, want deadbeef 0", s1_apb_prdata, s1_apb_pslverr);
    end
  endtask

  task automatic test_timeout;
    logic [DW-1:0] rd;
    logic err, tmo;
    int lat, bad;
    comp_stuck = 1'b1;
    xfer(0, 1'b0, 4'h7, 32'h0, rd, err, tmo, lat);
    vectors = vectors + 1;
    if (lat !== 18 || acc_len !== 16) begin
      miscompares = miscompares + 1;
      $display("FAIL tmo_timing: latency=%0d access_cycles=%0d, want 18 16", lat, acc_len);
    end
    vectors = vectors + 1;
    if (rd !== 32'h0 || err !== 1'b1 || tmo !== 1'b1 || timeout_count !== 8'd1) begin
      miscompares = miscompares + 1;
      $display("FAIL tmo_resp: prdata=%h pslverr=%b terr=%b tcnt=%0d, want 0 1 1 1",
               rd, err, tmo, timeout_count);
    end
    @(posedge clk);
    #1;
    vectors = vectors + 1;
    if (timeout_err !== 1'b0 || s0_apb_pslverr !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL tmo_pulse: terr=%b pslverr=%b one cycle later, want 0 0", timeout_err, s0_apb_pslverr);
    end
    bad = 0;
    for (int k = 0; k < 299; k++) begin
      xfer(0, 1'b0, 4'h7, 32'h0, rd, err, tmo, lat);
      if (err !== 1'b1 || tmo !== 1'b1 || rd !== 32'h0) bad = bad + 1;
    end
    vectors = vectors + 1;
    if (bad != 0 || timeout_count !== 8'd255) begin
      miscompares = miscompares + 1;
      $display("FAIL tmo_saturate: bad aborts=%0d tcnt=%0d, want 0 255", bad, timeout_count);
    end
    comp_stuck = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] rd0, rd1;
    logic e0, e1, t0, t1;
    int l0, l1, base;
    comp_stuck = 1'b1;
    s0_apb_paddr = 4'h9; s0_apb_pwrite = 1'b0; s0_apb_psel = 1'b1; s0_apb_penable = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      s0_apb_penable = 1'b1;
    end
    vectors = vectors + 1;
    if (m_apb_psel !== 1'b1 || m_apb_penable !== 1'b1 || grant !== 2'b01) begin
      miscompares = miscompares + 1;
      $display("FAIL mid_access: psel=%b pen=%b grant=%b, want 1 1 01", m_apb_psel, m_apb_penable, grant);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors = vectors + 1;
    if ({grant, m_apb_psel, m_apb_penable, m_apb_paddr, timeout_count, timeout_err} !== '0 ||
        {s0_apb_prdata, s0_apb_pready, s0_apb_pslverr} !== '0) begin
      miscompares = miscompares + 1;
      $display("FAIL mid_reset: grant=%b psel=%b pen=%b paddr=%h tcnt=%0d terr=%b s0rd=%h, want all 0",
               grant, m_apb_psel, m_apb_penable, m_apb_paddr, timeout_count, timeout_err, s0_apb_prdata);
    end
    s0_apb_psel = 1'b0; s0_apb_penable = 1'b0;
    comp_stuck = 1'b0; comp_waits = 1; comp_rdata = 32'h0000_3333;
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = grant_log.size();
    fork
      xfer(0, 1'b0, 4'hA, 32'h0, rd0, e0, t0, l0);
      xfer(1, 1'b0, 4'hB, 32'h0, rd1, e1, t1, l1);
    join
    vectors = vectors + 1;
    if (grant_log.size() != base + 2 || grant_log[base] !== 2'b01 || grant_log[base+1] !== 2'b10) begin
      miscompares = miscompares + 1;
      $display("FAIL post_reset_order: %0d grants %b %b, want 01 then 10",
               grant_log.size() - base, grant_log[base], grant_log[base+1]);
    end
    vectors = vectors + 1;
    if (l0 !== 4 || rd0 !== 32'h0000_3333 || e0 !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL post_reset_xfer: latency=%0d prdata=%h pslverr=%b, want 4 00003333 0", l0, rd0, e0);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1;
    s0_apb_paddr = '0; s0_apb_pwrite = 1'b0; s0_apb_psel = 1'b0; s0_apb_penable = 1'b0; s0_apb_pwdata = '0;
    s1_apb_paddr = '0; s1_apb_pwrite = 1'b0; s1_apb_psel = 1'b0; s1_apb_penable = 1'b0; s1_apb_pwdata = '0;
    m_apb_prdata = '0; m_apb_pready = 1'b0; m_apb_pslverr = 1'b0;
    comp_waits = 0; comp_stuck = 1'b0; comp_rdata = '0; comp_err = 1'b0;
    comp_cnt = 0; acc_len = 0; last_addr = '0; last_wdata = '0; last_write = 1'b0;
    prev_grant = 2'b00;
    test_reset();
    test_write();
    test_simultaneous();
    test_back_to_back();
    test_rdata_err();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
